// File: rtl/mr_latch_pkg.sv
// Shared types and defaults for the latch-comparator SAR controller.
package mr_latch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_SETTLE,
      ST_STROBE,
      ST_DECIDE,
      ST_DONE
   } sar_state_t;

   localparam int DEF_WIDTH         = 8;
   localparam int DEF_SAMPLE_CYCLES = 4;
   localparam int DEF_SETTLE_CYCLES = 2;

   // Cycle, counted from the accepting edge, in which done is high.
   function automatic int sar_latency(input int width, input int sample_cycles,
                                      input int settle_cycles);
      return sample_cycles + width * (settle_cycles + 2) + 1;
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that stops at zero; times the sample and settle phases.
module phase_timer #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/latch_cmp_sar_ctrl.sv
// SAR sequencer for a clocked latch comparator and external DAC.
//   state  | meaning
//   IDLE   | waiting for start, outputs quiet
//   SAMPLE | sampler tracking the input
//   SETTLE | DAC settling, comparator latch precharged
//   STROBE | comparator evaluating
//   DECIDE | comparator decision captured into the current bit
//   DONE   | result published, done pulsed
module latch_cmp_sar_ctrl
   import mr_latch_pkg::*;
#(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             cmp_in,
   output logic             sample_en,
   output logic             cmp_rst,
   output logic             cmp_strobe,
   output logic [WIDTH-1:0] dac_code,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2((SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES
                                                               : SETTLE_CYCLES) + 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
   localparam logic [WIDTH-1:0] MSB_CODE    = WIDTH'(1) << (WIDTH - 1);

   sar_state_t       state;
   logic [BW-1:0]    bit_idx;
   logic             tmr_load;
   logic [CW-1:0]    tmr_val;
   logic             tmr_zero;
   logic [WIDTH-1:0] trial_next;

   phase_timer #(.CW(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = SETTLE_LOAD;
      if (!abort) begin
         case (state)
            ST_IDLE:   if (start) begin
                          tmr_load = 1'b1;
                          tmr_val  = SAMPLE_LOAD;
                       end
            ST_SAMPLE: tmr_load = tmr_zero;
            ST_DECIDE: tmr_load = (bit_idx != '0);
            default:   tmr_load = 1'b0;
         endcase
      end
   end

   // Resolve the current bit and, if any remain, raise the next trial bit.
   always_comb begin
      trial_next          = dac_code;
      trial_next[bit_idx] = cmp_in;
      if (bit_idx != '0)
         trial_next[bit_idx - 1'b1] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         bit_idx    <= '0;
         sample_en  <= 1'b0;
         cmp_rst    <= 1'b0;
         cmp_strobe <= 1'b0;
         dac_code   <= '0;
         result     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (abort && state != ST_IDLE) begin
         state      <= ST_IDLE;
         bit_idx    <= '0;
         sample_en  <= 1'b0;
         cmp_rst    <= 1'b0;
         cmp_strobe <= 1'b0;
         dac_code   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  state     <= ST_SAMPLE;
                  bit_idx   <= BW'(WIDTH - 1);
                  dac_code  <= MSB_CODE;
                  sample_en <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            ST_SAMPLE: begin
               if (tmr_zero) begin
                  state     <= ST_SETTLE;
                  sample_en <= 1'b0;
                  cmp_rst   <= 1'b1;
               end
            end
            ST_SETTLE: begin
               if (tmr_zero) begin
                  state      <= ST_STROBE;
                  cmp_rst    <= 1'b0;
                  cmp_strobe <= 1'b1;
               end
            end
            ST_STROBE: begin
               state      <= ST_DECIDE;
               cmp_strobe <= 1'b0;
            end
            ST_DECIDE: begin
               dac_code <= trial_next;
               if (bit_idx != '0) begin
                  state   <= ST_SETTLE;
                  bit_idx <= bit_idx - 1'b1;
                  cmp_rst <= 1'b1;
               end else begin
                  state  <= ST_DONE;
                  result <= trial_next;
                  done   <= 1'b1;
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               dac_code <= '0;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_latch_cmp_sar_ctrl.sv
// Self-checking bench: ideal comparator against a binary-search reference model.
module tb_latch_cmp_sar_ctrl;
   import mr_latch_pkg::*;

   localparam int W   = 8;
   localparam int S   = 4;
   localparam int SE  = 2;
   localparam int LAT = sar_latency(W, S, SE);

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] vin = '0;
   logic         cmp_in;
   logic         sample_en, cmp_rst, cmp_strobe, busy, done;
   logic [W-1:0] dac_code, result;
   logic [W-1:0] last_res = '0;

   int n_chk = 0;
   int n_bad = 0;

   latch_cmp_sar_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(SE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cmp_in     (cmp_in),
      .sample_en  (sample_en),
      .cmp_rst    (cmp_rst),
      .cmp_strobe (cmp_strobe),
      .dac_code   (dac_code),
      .result     (result),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   assign cmp_in = (vin >= dac_code);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One conversion; abort_at/rst_at name the cycle whose closing edge cuts it (0 = none).
   task automatic conv(input logic [W-1:0] v, input int abort_at, input int rst_at,
                       input bit repulse);
      int           phase_err = 0, overlap = 0, done_cnt = 0, done_cyc = 0;
      int           trial_err = 0, n_str = 0, post_err = 0;
      int           cut_at, rel;
      bit           in_bits, exp_s, exp_r, exp_t;
      logic [W-1:0] code, trial, prev, exp_res;
      logic [W-1:0] exp_trial[W];

      prev   = last_res;
      cut_at = (abort_at > 0) ? abort_at : rst_at;
      code   = '0;
      for (int b = W - 1; b >= 0; b--) begin
         trial            = code | (W'(1) << b);
         exp_trial[W-1-b] = trial;
         if (v >= trial) code = trial;
      end
      exp_res = (rst_at > 0) ? '0 : ((cut_at > 0) ? prev : code);

      vin = v;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_cycle1", busy, 1);
      for (int cyc = 1; cyc <= LAT + 2; cyc++) begin
         if ((sample_en && cmp_rst) || (sample_en && cmp_strobe) || (cmp_rst && cmp_strobe))
            overlap++;
         done_cnt += done;
         if (done) done_cyc = cyc;
         if (cut_at > 0 && cyc > cut_at) begin
            if (busy || sample_en || cmp_rst || cmp_strobe || done || dac_code != '0 ||
                result !== exp_res)
               post_err++;
         end else begin
            rel     = cyc - S - 1;
            in_bits = (cyc > S) && (cyc <= S + W * (SE + 2));
            exp_s   = (cyc <= S);
            exp_r   = in_bits && (rel % (SE + 2) < SE);
            exp_t   = in_bits && (rel % (SE + 2) == SE);
            if (sample_en !== exp_s || cmp_rst !== exp_r || cmp_strobe !== exp_t ||
                done !== (cyc == LAT) || busy !== (cyc <= LAT))
               phase_err++;
            if (result !== ((cyc >= LAT) ? code : prev)) phase_err++;
            if (cyc > LAT && dac_code != '0) phase_err++;
            if (cmp_strobe) begin
               if (n_str >= W || dac_code !== exp_trial[n_str]) trial_err++;
               n_str++;
            end
         end
         start = repulse && (cyc == 5 || cyc == 20);
         abort = (cyc == abort_at);
         rst_n = !(cyc == rst_at);
         @(negedge clk);
      end
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;

      chk("phase_seq", phase_err, 0);
      chk("no_overlap", overlap, 0);
      if (cut_at == 0) begin
         chk("done_count", done_cnt, 1);
         chk("done_cycle", done_cyc, LAT);
         chk("trial_codes", trial_err, 0);
         chk("strobe_count", n_str, W);
         chk("result", result, code);
         last_res = code;
      end else begin
         chk("cut_no_done", done_cnt, 0);
         chk("cut_idle", post_err, 0);
         chk("cut_result", result, exp_res);
         last_res = exp_res;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_outputs", {sample_en, cmp_rst, cmp_strobe, busy, done}, 0);
      chk("rst_dac", dac_code, 0);
      chk("rst_result", result, 0);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      conv(8'h80, 0, 0, 1'b0);
      conv(8'hFF, 0, 0, 1'b0);
      conv(8'h00, 0, 0, 1'b0);
      conv(8'h5A, 0, 0, 1'b1);
      conv(8'h33, 0, 0, 1'b0);
      conv(W'($urandom), 15, 0, 1'b0);
      conv(W'($urandom), 0, 0, 1'b0);
      conv(W'($urandom), 0, 20, 1'b0);
      conv(8'hC3, 0, 0, 1'b0);
      for (int i = 0; i < 6; i++)
         conv(W'($urandom), 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
